multi_pulser: RTL and testbench
===============================

# multi_pulser

Multi-channel, parametrised successor to the single-channel glitch pulser. One start event launches up to `NUM_CH` independent pulse trains, each with its own delay, width, count and spacing. Configuration is latched at start, and the block supports a synchronous abort. It sits between the trigger/UART control logic and the glitch output pins, with one output per glitch transistor or probe.

## Interface
- `NUM_CH`, 2: number of independent channels (1..8)
- `DELAY_W`, 16: width of per-channel delay field
- `WIDTH_W`, 8: width of per-channel pulse-width field
- `COUNT_W`, 8: width of per-channel pulse-count field
- `SPACING_W`, 16: width of per-channel spacing field
- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  start request; only its rising edge (low at previous edge, high now) acts
- `abort_i`  in  1  synchronous abort; has priority over everything except `rst`
- `delay_i`  in  NUM_CH*DELAY_W  per-channel delay in clk cycles; channel c at bits [c*DELAY_W +: DELAY_W]
- `pulse_width_i`  in  NUM_CH*WIDTH_W  per-channel high time in cycles
- `num_pulses_i`  in  NUM_CH*COUNT_W  per-channel pulse count
- `pulse_spacing_i`  in  NUM_CH*SPACING_W  per-channel low time between pulses
- `pol_i`  in  NUM_CH  per-channel output inversion; present only with `MULTI_PULSER_POL_EN`
- `pulse_o`  out  NUM_CH  registered pulse outputs; reset 0
- `busy_o`  out  NUM_CH  per-channel active flag; reset 0
- `done_o`  out  1  one-cycle strobe when the last active channel finishes; reset 0

## Operation
- Per-channel FSM states: IDLE, DELAY, HIGH, LOW.
- Start event: rising edge of `en` sampled at edge T while all `busy_o` = 0.
  - All channel configs are latched at T.
  - A rising edge while any channel is busy is ignored and not queued.
- Disabled channel: `pulse_width` = 0 or `num_pulses` = 0.
  - The channel stays IDLE, `busy_o` stays 0, and `pulse_o` stays inactive.
- IDLE to DELAY: on start; skipped directly to HIGH if delay = 0.
- DELAY: counts delay cycles, then goes to HIGH.
- HIGH: lasts exactly `pulse_width` cycles.
  - Decrements the remaining-pulse counter on exit.
  - Goes to IDLE if the counter reaches 0, else to LOW.
- LOW: lasts `max(spacing,1)` cycles. Spacing 0 is treated as 1 so that consecutive pulses stay distinguishable. Then goes to HIGH.
- Counters are the same width as their fields and never wrap. Maximum values give full-length intervals: 65535-cycle delay, 255-cycle width.
- Abort at edge A: every channel goes to IDLE at A+1, and `pulse_o`/`busy_o` are 0 at A+1. `done_o` is not asserted for an aborted run.
- Abort coinciding with a start edge: abort wins and nothing starts.
- Reset mid-train: outputs drop immediately (asynchronous) and the FSMs go to IDLE. The `en` edge detector register resets to 1, so an `en` held high through reset does not trigger.

## Timing
- Start edge at T, delay d, width w, spacing s, count n:
  - `busy_o[c]` = 1 from T+1.
  - First `pulse_o[c]` high from T+1+d through T+d+w.
  - Pulse k (0-based) begins at T+1+d+k*(w+max(s,1)).
  - `busy_o[c]` falls in the same cycle `pulse_o[c]` falls after the last pulse.
- `done_o` is high for exactly one cycle: the first cycle in which the OR of `busy_o` returns to 0 after a start with at least one enabled channel.
- All outputs are registered, with no combinational path from inputs to outputs.
- The earliest next accepted start edge is the cycle `done_o` is high.

## Configuration
- `MULTI_PULSER_POL_EN` defined:
  - The `pol_i` port exists and is latched at start.
  - `pulse_o[c]` = internal pulse XOR latched `pol[c]`.
  - Idle and reset level is still 0 before the first start. After a start, the idle level equals the latched `pol[c]`.
- Not defined:
  - No `pol_i` port, and outputs are active-high only.

## Structure
- Package `pulser_pkg`:
  - state enum (IDLE, DELAY, HIGH, LOW)
  - default field-width localparams
- Sub-module `pulser_channel`:
  - one FSM plus counters, holding its latched config
  - instantiated NUM_CH times by a generate loop
- Top level owns:
  - `en` edge detector
  - start gating on aggregate busy
  - abort fan-out
  - `done_o` generation

## Test plan
- NUM_CH=2. ch0 d=3,w=2,n=3,s=4; ch1 d=0,w=1,n=1,s=0. Start at T.
  - ch0 high T+4..T+5, T+10..T+11, T+16..T+17.
  - ch1 high T+1 only.
  - `done_o` at T+18.
- Disabled channel: ch1 w=0, ch0 d=0,w=1,n=1. Start.
  - `busy_o[1]` never rises.
  - `done_o` one cycle after ch0's pulse.
- Spacing 0: w=1,n=3,s=0 → pulses at T+1, T+3, T+5, each separated by one low cycle.
- Second `en` rising edge at T+2 during a busy train → ignored; the pulse sequence is identical to a single start.
- `abort_i` at T+5 mid-pulse → all `pulse_o`/`busy_o` = 0 at T+6; `done_o` stays 0. A later start works normally.
- `rst` asserted mid-delay with `en` held high through release → outputs 0 immediately, and no start after release until `en` toggles. With `MULTI_PULSER_POL_EN`, `pol_i[0]`=1 gives an idle-high, active-low train.

Source files
------------

// File: rtl/pulser_pkg.sv
// Shared types and default field widths for the multi-channel pulser.
package pulser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  localparam int NUM_CH_DEF    = 2;
  localparam int DELAY_W_DEF   = 16;
  localparam int WIDTH_W_DEF   = 8;
  localparam int COUNT_W_DEF   = 8;
  localparam int SPACING_W_DEF = 16;

endpackage

// File: rtl/pulser_channel.sv
// One pulse-train channel: latched config, down-counters and a four-state FSM.
//   state | meaning
//   IDLE  | waiting for start; output at idle level
//   DELAY | counting initial delay
//   HIGH  | pulse active for width cycles
//   LOW   | gap between pulses, max(spacing,1) cycles
module pulser_channel
  import pulser_pkg::*;
#(
  parameter int DELAY_W   = DELAY_W_DEF,
  parameter int WIDTH_W   = WIDTH_W_DEF,
  parameter int COUNT_W   = COUNT_W_DEF,
  parameter int SPACING_W = SPACING_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DELAY_W-1:0]   delay,
  input  logic [WIDTH_W-1:0]   width,
  input  logic [COUNT_W-1:0]   count,
  input  logic [SPACING_W-1:0] spacing,
  input  logic                 pol,
  output logic                 pulse,
  output logic                 busy,
  output logic                 finishing
);

  state_t               state;
  logic [DELAY_W-1:0]   dly_cnt;
  logic [WIDTH_W-1:0]   wid_cnt;
  logic [WIDTH_W-1:0]   wid_lat;
  logic [COUNT_W-1:0]   rem_cnt;
  logic [SPACING_W-1:0] spc_cnt;
  logic [SPACING_W-1:0] spc_lat;
  logic                 pol_lat;

  // True in the final HIGH cycle of the final pulse: busy drops at the next edge.
  assign finishing = (state == HIGH) && (wid_cnt == WIDTH_W'(1)) && (rem_cnt == COUNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dly_cnt <= '0;
      wid_cnt <= '0;
      wid_lat <= '0;
      rem_cnt <= '0;
      spc_cnt <= '0;
      spc_lat <= '0;
      pol_lat <= 1'b0;
      pulse   <= 1'b0;
      busy    <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      pulse <= pol_lat;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pol_lat <= pol;
            if (width == '0 || count == '0) begin
              pulse <= pol;
            end else begin
              wid_lat <= width;
              spc_lat <= spacing;
              rem_cnt <= count;
              busy    <= 1'b1;
              if (delay == '0) begin
                state   <= HIGH;
                wid_cnt <= width;
                pulse   <= ~pol;
              end else begin
                state   <= DELAY;
                dly_cnt <= delay;
                pulse   <= pol;
              end
            end
          end
        end
        DELAY: begin
          if (dly_cnt == DELAY_W'(1)) begin
            state   <= HIGH;
            wid_cnt <= wid_lat;
            pulse   <= ~pol_lat;
          end else begin
            dly_cnt <= dly_cnt - DELAY_W'(1);
          end
        end
        HIGH: begin
          if (wid_cnt == WIDTH_W'(1)) begin
            pulse   <= pol_lat;
            rem_cnt <= rem_cnt - COUNT_W'(1);
            if (rem_cnt == COUNT_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= LOW;
              spc_cnt <= (spc_lat == '0) ? SPACING_W'(1) : spc_lat;
            end
          end else begin
            wid_cnt <= wid_cnt - WIDTH_W'(1);
          end
        end
        LOW: begin
          if (spc_cnt == SPACING_W'(1)) begin
            state   <= HIGH;
            wid_cnt <= wid_lat;
            pulse   <= ~pol_lat;
          end else begin
            spc_cnt <= spc_cnt - SPACING_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          pulse <= pol_lat;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_pulser.sv
// Multi-channel glitch pulser top: en edge detect, start gating, abort fan-out, done strobe.
// Optional per-channel output inversion when MULTI_PULSER_POL_EN is defined.
module multi_pulser
  import pulser_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int DELAY_W   = DELAY_W_DEF,
  parameter int WIDTH_W   = WIDTH_W_DEF,
  parameter int COUNT_W   = COUNT_W_DEF,
  parameter int SPACING_W = SPACING_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          abort_i,
  input  logic [NUM_CH*DELAY_W-1:0]     delay_i,
  input  logic [NUM_CH*WIDTH_W-1:0]     pulse_width_i,
  input  logic [NUM_CH*COUNT_W-1:0]     num_pulses_i,
  input  logic [NUM_CH*SPACING_W-1:0]   pulse_spacing_i,
`ifdef MULTI_PULSER_POL_EN
  input  logic [NUM_CH-1:0]             pol_i,
`endif
  output logic [NUM_CH-1:0]             pulse_o,
  output logic [NUM_CH-1:0]             busy_o,
  output logic                          done_o
);

  logic              en_q;
  logic              start;
  logic [NUM_CH-1:0] fin;
  logic [NUM_CH-1:0] pol;

`ifdef MULTI_PULSER_POL_EN
  assign pol = pol_i;
`else
  assign pol = '0;
`endif

  // en_q resets high so an en held through reset is not seen as a rising edge.
  assign start = en && !en_q && !(|busy_o) && !abort_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= 1'b1;
      done_o <= 1'b0;
    end else begin
      en_q   <= en;
      done_o <= (|busy_o) && !(|(busy_o & ~fin)) && !abort_i;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pulser_channel #(
      .DELAY_W  (DELAY_W),
      .WIDTH_W  (WIDTH_W),
      .COUNT_W  (COUNT_W),
      .SPACING_W(SPACING_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort_i),
      .delay    (delay_i[c*DELAY_W +: DELAY_W]),
      .width    (pulse_width_i[c*WIDTH_W +: WIDTH_W]),
      .count    (num_pulses_i[c*COUNT_W +: COUNT_W]),
      .spacing  (pulse_spacing_i[c*SPACING_W +: SPACING_W]),
      .pol      (pol[c]),
      .pulse    (pulse_o[c]),
      .busy     (busy_o[c]),
      .finishing(fin[c])
    );
  end

endmodule

// File: tb/tb_multi_pulser.sv
// Directed self-checking bench for multi_pulser (NUM_CH=2, default widths).
module tb_multi_pulser;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        abort_i;
  logic [31:0] delay_i;
  logic [15:0] pulse_width_i;
  logic [15:0] num_pulses_i;
  logic [31:0] pulse_spacing_i;
`ifdef MULTI_PULSER_POL_EN
  logic [1:0]  pol_i;
`endif
  logic [1:0]  pulse_o;
  logic [1:0]  busy_o;
  logic        done_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multi_pulser dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .abort_i        (abort_i),
    .delay_i        (delay_i),
    .pulse_width_i  (pulse_width_i),
    .num_pulses_i   (num_pulses_i),
    .pulse_spacing_i(pulse_spacing_i),
`ifdef MULTI_PULSER_POL_EN
    .pol_i          (pol_i),
`endif
    .pulse_o        (pulse_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  task automatic set_cfg(input int d0, w0, n0, s0, d1, w1, n1, s1);
    delay_i         = {16'(d1), 16'(d0)};
    pulse_width_i   = {8'(w1), 8'(w0)};
    num_pulses_i    = {8'(n1), 8'(n0)};
    pulse_spacing_i = {16'(s1), 16'(s0)};
  endtask

  // Raise en just before edge T; the next negedge observes cycle T+1.
  task automatic fire();
    @(negedge clk);
    en = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; abort_i = 1'b0;
`ifdef MULTI_PULSER_POL_EN
    pol_i = 2'b00;
`endif
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    n_cmp++;
    if ({pulse_o, busy_o, done_o} !== 5'b0) begin
      n_bad++; $display("FAIL reset outputs got %b want 00000", {pulse_o, busy_o, done_o});
    end
    rst = 1'b0;
    idle(2);
    n_cmp++;
    if ({pulse_o, busy_o, done_o} !== 5'b0) begin
      n_bad++; $display("FAIL post_reset outputs got %b want 00000", {pulse_o, busy_o, done_o});
    end
  endtask

  task automatic test_basic(input bit retrigger);
    logic [1:0] ep, eb;
    logic       ed;
    set_cfg(3, 2, 3, 4, 0, 1, 1, 0);
    fire();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      ep[0] = (k inside {4, 5, 10, 11, 16, 17});
      ep[1] = (k == 1);
      eb[0] = (k >= 1 && k <= 17);
      eb[1] = (k == 1);
      ed    = (k == 18);
      n_cmp++;
      if (pulse_o !== ep) begin
        n_bad++; $display("FAIL basic%0d pulse k=%0d got %b want %b", retrigger, k, pulse_o, ep);
      end
      n_cmp++;
      if (busy_o !== eb) begin
        n_bad++; $display("FAIL basic%0d busy k=%0d got %b want %b", retrigger, k, busy_o, eb);
      end
      n_cmp++;
      if (done_o !== ed) begin
        n_bad++; $display("FAIL basic%0d done k=%0d got %b want %b", retrigger, k, done_o, ed);
      end
      if (k == 1) en = 1'b0;
      if (k == 2 && retrigger) en = 1'b1;
      if (k == 3) en = 1'b0;
    end
  endtask

  task automatic test_disabled();
    set_cfg(0, 1, 1, 0, 0, 0, 1, 0);
    fire();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (busy_o !== {1'b0, k == 1}) begin
        n_bad++; $display("FAIL disabled busy k=%0d got %b want %b", k, busy_o, {1'b0, k == 1});
      end
      n_cmp++;
      if (pulse_o !== {1'b0, k == 1}) begin
        n_bad++; $display("FAIL disabled pulse k=%0d got %b want %b", k, pulse_o, {1'b0, k == 1});
      end
      n_cmp++;
      if (done_o !== (k == 2)) begin
        n_bad++; $display("FAIL disabled done k=%0d got %b want %b", k, done_o, k == 2);
      end
      if (k == 1) en = 1'b0;
    end
  endtask

  task automatic test_spacing0();
    logic ep;
    set_cfg(0, 1, 3, 0, 0, 1, 0, 0);
    fire();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      ep = (k inside {1, 3, 5});
      n_cmp++;
      if (pulse_o !== {1'b0, ep}) begin
        n_bad++; $display("FAIL spacing0 pulse k=%0d got %b want %b", k, pulse_o, {1'b0, ep});
      end
      n_cmp++;
      if (done_o !== (k == 6)) begin
        n_bad++; $display("FAIL spacing0 done k=%0d got %b want %b", k, done_o, k == 6);
      end
      if (k == 1) en = 1'b0;
    end
  endtask

  task automatic test_max_width();
    int highs = 0;
    int done_at = -1;
    set_cfg(0, 255, 1, 0, 0, 0, 0, 0);
    fire();
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk);
      if (pulse_o[0]) highs++;
      if (done_o && done_at < 0) done_at = k;
      if (k == 1) en = 1'b0;
    end
    n_cmp++;
    if (highs !== 255) begin
      n_bad++; $display("FAIL max_width high_cycles got %0d want 255", highs);
    end
    n_cmp++;
    if (done_at !== 256) begin
      n_bad++; $display("FAIL max_width done_cycle got %0d want 256", done_at);
    end
  endtask

  task automatic test_abort();
    set_cfg(3, 2, 3, 4, 0, 1, 1, 0);
    fire();
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 5) begin
        n_cmp++;
        if (pulse_o !== 2'b01) begin
          n_bad++; $display("FAIL abort pre_pulse got %b want 01", pulse_o);
        end
        abort_i = 1'b1;
      end
      if (k == 6) begin
        abort_i = 1'b0;
        n_cmp++;
        if ({pulse_o, busy_o} !== 4'b0) begin
          n_bad++; $display("FAIL abort outputs got %b want 0000", {pulse_o, busy_o});
        end
      end
      if (k > 6 && busy_o !== 2'b00) begin
        n_cmp++; n_bad++; $display("FAIL abort busy_after k=%0d got %b want 00", k, busy_o);
      end
      if (done_o !== 1'b0) begin
        n_cmp++; n_bad++; $display("FAIL abort done k=%0d got %b want 0", k, done_o);
      end
      if (k == 1) en = 1'b0;
    end
    set_cfg(0, 1, 1, 0, 0, 1, 1, 0);
    fire();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({pulse_o, done_o} !== {(k == 1) ? 2'b11 : 2'b00, k == 2}) begin
        n_bad++; $display("FAIL abort restart k=%0d got %b want %b", k, {pulse_o, done_o},
                          {(k == 1) ? 2'b11 : 2'b00, k == 2});
      end
      if (k == 1) en = 1'b0;
    end
  endtask

  task automatic test_abort_start();
    set_cfg(0, 1, 1, 0, 0, 1, 1, 0);
    @(negedge clk);
    en = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      n_cmp++;
      if ({busy_o, pulse_o} !== 4'b0) begin
        n_bad++; $display("FAIL abort_start k=%0d got %b want 0000", k, {busy_o, pulse_o});
      end
      @(negedge clk);
    end
    en = 1'b0;
    idle(2);
  endtask

  task automatic test_reset_mid();
    set_cfg(3, 2, 3, 4, 0, 1, 1, 0);
    fire();
    idle(2);
    n_cmp++;
    if (busy_o !== 2'b01) begin
      n_bad++; $display("FAIL rst_mid busy_before got %b want 01", busy_o);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({pulse_o, busy_o, done_o} !== 5'b0) begin
      n_bad++; $display("FAIL rst_mid async got %b want 00000", {pulse_o, busy_o, done_o});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if (busy_o !== 2'b00) begin
        n_bad++; $display("FAIL rst_mid held_en k=%0d got %b want 00", k, busy_o);
      end
    end
    en = 1'b0;
    fire();
    @(negedge clk);
    en = 1'b0;
    n_cmp++;
    if (busy_o !== 2'b11) begin
      n_bad++; $display("FAIL rst_mid restart busy got %b want 11", busy_o);
    end
    idle(20);
  endtask

`ifdef MULTI_PULSER_POL_EN
  task automatic test_pol();
    logic ep;
    pol_i = 2'b01;
    set_cfg(1, 2, 1, 0, 0, 0, 0, 0);
    fire();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      ep = !(k == 2 || k == 3);
      n_cmp++;
      if (pulse_o[0] !== ep) begin
        n_bad++; $display("FAIL pol pulse k=%0d got %b want %b", k, pulse_o[0], ep);
      end
      if (k == 1) en = 1'b0;
    end
    pol_i = 2'b00;
  endtask
`endif

  initial begin
    test_reset();
    test_basic(1'b0);
    idle(3);
    test_disabled();
    idle(3);
    test_spacing0();
    idle(3);
    test_basic(1'b1);
    idle(3);
    test_max_width();
    idle(3);
    test_abort();
    idle(3);
    test_abort_start();
    test_reset_mid();
`ifdef MULTI_PULSER_POL_EN
    test_pol();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
